// File: rtl/char_cursor_ctrl.sv
// Character-cell cursor controller: turns a UART byte stream into text-RAM
// writes for a COLS x ROWS character display. It handles printable bytes and
// the CR, LF, BS and FF control codes, and clears the whole screen by writing
// a space to every cell.
module char_cursor_ctrl #(
  parameter int unsigned COLS = 40,
  parameter int unsigned ROWS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_busy,
  output logic       o_drop,
  output logic       o_wr_en,
  output logic [9:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic [5:0] o_cursor_col,
  output logic [3:0] o_cursor_row
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [9:0] LAST_IDX = 10'(COLS * ROWS - 1);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [9:0] COLS_W   = 10'(COLS);
  localparam logic [7:0] SPACE    = 8'h20;

  state_t     state;
  logic [9:0] sweep_idx;
  logic [9:0] cur_addr;

  // Linear text-RAM address of the cell under the cursor.
  always_comb begin
    cur_addr = 10'(o_cursor_row) * COLS_W + 10'(o_cursor_col);
  end

  // Clear sweep, byte decode, cursor movement and all registered outputs.
  // o_busy follows the state with a one-cycle lag, so it is high exactly
  // while the sweep's write strobes are visible on o_wr_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLEAR;
      sweep_idx    <= '0;
      o_busy       <= 1'b1;
      o_drop       <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= SPACE;
      o_cursor_col <= '0;
      o_cursor_row <= '0;
    end else begin
      o_wr_en <= 1'b0;
      o_drop  <= 1'b0;
      o_busy  <= (state == CLEAR);
      case (state)
        CLEAR: begin
          o_wr_en   <= 1'b1;
          o_wr_addr <= sweep_idx;
          o_wr_data <= SPACE;
          o_drop    <= i_rx_dv;
          if (sweep_idx == LAST_IDX) begin
            sweep_idx <= '0;
            state     <= IDLE;
          end else begin
            sweep_idx <= sweep_idx + 10'd1;
          end
        end
        IDLE: begin
          if (i_rx_dv) begin
            if (i_rx_byte >= 8'h20 && i_rx_byte <= 8'h7E) begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= cur_addr;
              o_wr_data <= i_rx_byte;
              if (o_cursor_col == LAST_COL) begin
                o_cursor_col <= '0;
                o_cursor_row <= (o_cursor_row == LAST_ROW) ? '0 : o_cursor_row + 4'd1;
              end else begin
                o_cursor_col <= o_cursor_col + 6'd1;
              end
            end else begin
              case (i_rx_byte)
                8'h0D: o_cursor_col <= '0;
                8'h0A: o_cursor_row <= (o_cursor_row == LAST_ROW) ? '0 : o_cursor_row + 4'd1;
                8'h08: begin
                  if (o_cursor_col != '0) begin
                    o_cursor_col <= o_cursor_col - 6'd1;
                    o_wr_en      <= 1'b1;
                    o_wr_addr    <= cur_addr - 10'd1;
                    o_wr_data    <= SPACE;
                  end
                end
                8'h0C: begin
                  o_cursor_col <= '0;
                  o_cursor_row <= '0;
                  sweep_idx    <= '0;
                  state        <= CLEAR;
                end
                default: ;
              endcase
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: doc/char_cursor_ctrl.md
CHAR_CURSOR_CTRL -- requirements
Module: char_cursor_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 40, meaning text columns (640 px / 16 px glyph width).
REQ-002 SHALL have parameter ROWS, default 15, meaning text rows (480 px / 32 px glyph height).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge; single clock domain.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_rx_dv  input  1  one-cycle strobe from the UART receiver; byte valid.
REQ-006 SHALL have port i_rx_byte  input  8  received ASCII byte; sampled only when i_rx_dv=1.
REQ-007 SHALL have port o_busy  output  1  high while a clear sweep is in progress.
REQ-008 SHALL have port o_drop  output  1  one-cycle pulse when a byte is discarded.
REQ-009 SHALL have port o_wr_en  output  1  text-RAM write strobe.
REQ-010 SHALL have port o_wr_addr  output  10  text-RAM cell address, row*COLS+col.
REQ-011 SHALL have port o_wr_data  output  8  text-RAM write data (ASCII).
REQ-012 SHALL have port o_cursor_col  output  6  current cursor column.
REQ-013 SHALL have port o_cursor_row  output  4  current cursor row.

Function
REQ-014 SHALL implement a state machine with two states: CLEAR and IDLE.
REQ-015 SHALL register all outputs; no combinational path from any input to any output.
REQ-016 CLEAR SHALL write 0x20 to each address 0..COLS*ROWS-1 in ascending order, one write per cycle, then enter IDLE.
- o_busy=1 for the whole sweep.
- o_busy=0 from the first IDLE cycle.
REQ-017 In IDLE, a byte SHALL be accepted when i_rx_dv=1; any resulting write appears on o_wr_* exactly one cycle later; cursor outputs update in the same cycle.
REQ-018 Printable bytes 0x20..0x7E SHALL be written at the current cursor, after which the cursor advances:
- col+1.
- At col=COLS-1: col=0, row+1.
- At (COLS-1, ROWS-1): wrap to (0,0); no clear.
REQ-019 0x0D (CR) SHALL set col=0 with no write.
REQ-020 0x0A (LF) SHALL set row=row+1 with no write, wrapping ROWS-1 -> 0; col unchanged.
REQ-021 0x08 (BS) at col>0 SHALL set col=col-1 and write 0x20 at the new position; at col=0 it has no effect and no write.
REQ-022 0x0C (FF) SHALL home the cursor to (0,0) and enter CLEAR on the next cycle.
REQ-023 All other byte values SHALL be ignored: no write, no cursor change, no o_drop.
REQ-024 i_rx_dv=1 while in CLEAR SHALL discard the byte and pulse o_drop for one cycle; the sweep continues unaffected.
REQ-025 o_wr_en SHALL be 0 in every cycle with no write; o_wr_addr and o_wr_data hold their last values when o_wr_en=0.
REQ-026 o_cursor_col SHALL never exceed COLS-1, o_cursor_row SHALL never exceed ROWS-1, and o_wr_addr SHALL never exceed COLS*ROWS-1.

Reset
REQ-027 While rst=1 the block SHALL hold:
- state=CLEAR, sweep index=0.
- o_busy=1, o_drop=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0x20.
- cursor=(0,0).
REQ-028 The first cycle after rst deasserts SHALL write address 0, so the power-on sweep takes exactly COLS*ROWS cycles.
REQ-029 rst asserted mid-sweep or mid-write SHALL abort the operation and restart per REQ-027 on the next edge.

Verification
REQ-030 Release reset -> exactly 600 writes of 0x20 to addresses 0..599 in consecutive cycles; o_busy falls the cycle after address 599 is written.
REQ-031 In IDLE, send 'A' (0x41) then 'B' -> writes (addr 0, 0x41) then (addr 1, 0x42); cursor=(2,0).
REQ-032 Cursor at (39,14), send 0x5A -> write at addr 599 and cursor=(0,0); then send LF at (5,14) -> cursor=(5,0).
REQ-033 Cursor at (3,2), send BS -> write (addr 82, 0x20) and cursor=(2,2); at (0,2), send BS -> no write and cursor unchanged.
REQ-034 Send FF, then strobe i_rx_dv 10 cycles later -> o_drop pulses once, the 600-cycle sweep completes, and cursor=(0,0).
REQ-035 Assert rst at sweep address 300 -> o_wr_en=0 during reset; after release the sweep restarts at address 0.
